// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and op classification for the sequential ALU.
// The divider op is iterative only when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == ALU_MULT) || (op == ALU_DIV);
`else
        return (op == ALU_MULT);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the EX stage (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluCtr;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] aluRes;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divz;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, aluCtr, input1, input2,
        input  aluRes, zero, overflow, hi, lo, divz, err, busy, done
    );

    modport slave (
        input  start, aluCtr, input1, input2,
        output aluRes, zero, overflow, hi, lo, divz, err, busy, done
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Shift-add multiplier / restoring divider (divider only with ALU_SEQ_DIV_EN), one bit per i_step.
// o_hi_nxt/o_lo_nxt expose the post-step value so the caller can capture the final iteration.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
`ifdef ALU_SEQ_DIV_EN
    input  logic             i_is_div,
    output logic             o_is_div,
    output logic             o_divz,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt,
    output logic             o_last
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;

    // Multiply: {hi,lo} shifts right, multiplicand added into hi when lo[0] is set.
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_hi_m;
    logic [WIDTH-1:0] w_lo_m;

    assign w_madd = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
    assign w_hi_m = w_madd[WIDTH:1];
    assign w_lo_m = {w_madd[0], r_lo[WIDTH-1:1]};
    assign o_last = (r_cnt == CNT_W'(1));

`ifdef ALU_SEQ_DIV_EN
    logic             r_is_div;
    logic             r_divz;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] w_lo_d;

    // Divide: remainder in hi, dividend shifts out of lo as quotient bits shift in.
    assign w_rs   = {r_hi, r_lo[WIDTH-1]};
    assign w_diff = w_rs - {1'b0, r_b};
    assign w_ge   = (w_rs >= {1'b0, r_b});
    assign w_hi_d = w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
    assign w_lo_d = {r_lo[WIDTH-2:0], w_ge};

    assign o_is_div = r_is_div;
    assign o_divz   = r_divz;

    // A zero divisor preloads the final answer and freezes the datapath.
    always_comb begin
        o_hi_nxt = w_hi_m;
        o_lo_nxt = w_lo_m;
        if (r_divz) begin
            o_hi_nxt = r_hi;
            o_lo_nxt = r_lo;
        end else if (r_is_div) begin
            o_hi_nxt = w_hi_d;
            o_lo_nxt = w_lo_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_divz   <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_divz   <= i_is_div && (i_b == '0);
        end
    end
`else
    assign o_hi_nxt = w_hi_m;
    assign o_lo_nxt = w_lo_m;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_INIT;
`ifdef ALU_SEQ_DIV_EN
            if (i_is_div) begin
                r_b  <= i_b;
                r_hi <= (i_b == '0) ? i_a : '0;
                r_lo <= (i_b == '0) ? '1 : i_a;
            end else begin
                r_b  <= i_a;
                r_hi <= '0;
                r_lo <= i_b;
            end
`else
            r_b  <= i_a;
            r_hi <= '0;
            r_lo <= i_b;
`endif
        end else if (i_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_hi  <= o_hi_nxt;
            r_lo  <= o_lo_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked MIPS ALU: basic ops finish one cycle after accept, MULT/DIV after WIDTH+1; start is
// ignored while busy (the pipeline stalls on busy). ALU_SEQ_DIV_EN enables the divider.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;
    logic             w_load;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_last;

    assign w_a    = bus.input1;
    assign w_b    = bus.input2;
    assign w_sum  = w_a + w_b;
    assign w_dif  = w_a - w_b;
    assign w_load = (r_state == IDLE) && bus.start && is_iter_op(bus.aluCtr);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (bus.aluCtr)
            ALU_AND: w_res = w_a & w_b;
            ALU_OR:  w_res = w_a | w_b;
            ALU_ADD: begin
                w_res = w_sum;
                w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
            end
            ALU_SUB: begin
                w_res = w_dif;
                w_ovf = (w_a[MSB] != w_b[MSB]) && (w_dif[MSB] != w_a[MSB]);
            end
            ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            ALU_NOR: w_res = ~(w_a | w_b);
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    logic r_divz;
    logic w_is_div;
    logic w_divz;

    alu_seq_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (r_state == ITER),
        .i_is_div (bus.aluCtr == ALU_DIV),
        .o_is_div (w_is_div),
        .o_divz   (w_divz),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt),
        .o_last   (w_last)
    );
    assign bus.divz = r_divz;
`else
    alu_seq_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (r_state == ITER),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt),
        .o_last   (w_last)
    );
    assign bus.divz = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_divz  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_busy <= 1'b1;
                    if (is_iter_op(bus.aluCtr)) begin
                        r_state <= ITER;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_res   <= w_res;
                        r_zero  <= (w_res == '0);
                        r_ovf   <= w_ovf;
                        r_err   <= w_ill;
                    end
                end
                ITER: if (w_last) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_res   <= w_lo_nxt;
                    r_zero  <= (w_lo_nxt == '0);
                    r_ovf   <= 1'b0;
                    r_err   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
                    if (w_is_div) r_divz <= w_divz;
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aluRes   = r_res;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;
    assign bus.err      = r_err;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
